// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin grant in IDLE, then SETUP/ACCESS sequencing with one-cycle response.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic [DATA_WIDTH-1:0]   PRDATA
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t state, nstate;
   logic [1:0] grant;
   logic       gsel;
   logic       last_grant;
   logic       owner;
   logic       timeout;
   logic       done;
   logic       psel_d, penable_d;

   // Grant is gated by reset so req_ready drops the instant PRESETn falls.
   always_comb begin
      grant = 2'b00;
      if (state == IDLE && PRESETn) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;
   assign gsel      = grant[1];

`ifdef APB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         wait_cnt <= '0;
      else if (state == SETUP)
         wait_cnt <= '0;
      else if (state == ACCESS && !PREADY)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // Fires on the TIMEOUT_CYCLES-th ACCESS cycle still lacking PREADY.
   assign timeout = (state == ACCESS) && !PREADY && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign done = (state == ACCESS) && (PREADY || timeout);

   // State register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= nstate;
   end

   // Next-state logic
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (grant != 2'b00) nstate = SETUP;
         SETUP:   nstate = ACCESS;
         ACCESS:  if (done) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Output logic: APB control for the upcoming cycle, registered below
   always_comb begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      case (nstate)
         SETUP:   psel_d = 1'b1;
         ACCESS:  begin psel_d = 1'b1; penable_d = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
      end else begin
         PSEL    <= psel_d;
         PENABLE <= penable_d;
      end
   end

   // Address/data registers double as the transfer latches; they hold through ACCESS.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PWDATA     <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else if (grant != 2'b00) begin
         PADDR      <= gsel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
         PWRITE     <= req_write[gsel];
         PWDATA     <= req_write[gsel] ?
                       (gsel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0]) :
                       '0;
         owner      <= gsel;
         last_grant <= gsel;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 2'b00;
         if (done) begin
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
            rsp_err   <= PREADY ? PSLVERR : 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: reset, write, waited read, contention, mid-transfer reset, timeout/no-timeout.
module tb_apb_rr_master;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          PCLK, PRESETn;
   logic [1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
   logic [AW-1:0] PADDR;
   logic          rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

   int n_cmp = 0;
   int n_err = 0;

   apb_rr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      PRESETn   = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;
      #1;
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_data", {PADDR, PWDATA}, 0);
      chk("rst_rsp_data", {rsp_err, rsp_rdata}, 0);
      tick(); tick();
      PRESETn = 1'b1;
      tick();

      // Single write, zero waits, requester 0
      req_valid = 2'b01; req_write = 2'b01;
      req_addr[AW-1:0] = 32'h10; req_wdata[DW-1:0] = 32'hA5A5_0001;
      #1 chk("wr_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      #1;
      chk("wr_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b101);
      chk("wr_setup_addr", PADDR, 32'h10);
      chk("wr_setup_data", PWDATA, 32'hA5A5_0001);
      chk("wr_no_ready_setup", req_ready, 0);
      tick();
      chk("wr_access_ctl", {PSEL, PENABLE, PWRITE}, 3'b111);
      chk("wr_access_addr", PADDR, 32'h10);
      tick();
      chk("wr_rsp_valid", rsp_valid, 2'b01);
      chk("wr_rsp_err", rsp_err, 0);
      chk("wr_rsp_rdata", rsp_rdata, 0);
      chk("wr_idle_psel", PSEL, 0);
      tick();
      chk("wr_rsp_pulse", rsp_valid, 0);

      // Read with 3 wait states, requester 1, slave error
      PREADY = 1'b0;
      req_valid = 2'b10; req_write = 2'b00;
      req_addr[2*AW-1:AW] = 32'h20; req_wdata[2*DW-1:DW] = 32'h1234_5678;
      #1 chk("rd_grant", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      chk("rd_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b100);
      chk("rd_setup_wdata0", PWDATA, 0);
      chk("rd_setup_addr", PADDR, 32'h20);
      tick(); tick(); tick();
      chk("rd_wait3_ctl", {PSEL, PENABLE}, 2'b11);
      chk("rd_wait3_rsp", rsp_valid, 0);
      tick();
      PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
      #1 chk("rd_access4_ctl", {PSEL, PENABLE}, 2'b11);
      tick();
      PSLVERR = 1'b0; PRDATA = '0;
      chk("rd_rsp_valid", rsp_valid, 2'b10);
      chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("rd_rsp_err", rsp_err, 1);
      chk("rd_idle_psel", PSEL, 0);

      // Contention: both valid, grants alternate 0,1,0,1
      req_valid = 2'b11; req_write = 2'b00;
      req_addr = {32'h200, 32'h100};
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_g;
         exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
         #1 chk($sformatf("rr_grant%0d", k), req_ready, exp_g);
         tick();
         chk($sformatf("rr_addr%0d", k), PADDR, (k % 2 == 1) ? 32'h200 : 32'h100);
         chk($sformatf("rr_noready%0d", k), req_ready, 0);
         tick(); tick();
         chk($sformatf("rr_rsp%0d", k), rsp_valid, exp_g);
      end
      req_valid = 2'b00;
      tick();

      // Reset in ACCESS with PREADY low; last_grant left at 0 beforehand
      PREADY = 1'b0;
      req_valid = 2'b01; req_write = 2'b01;
      req_addr[AW-1:0] = 32'h30; req_wdata[DW-1:0] = 32'h0000_0BAD;
      #1 chk("mr_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      tick(); tick();
      chk("mr_in_access", {PSEL, PENABLE}, 2'b11);
      #2 PRESETn = 1'b0;
      #1;
      chk("mr_ctl_zero", {PSEL, PENABLE, PWRITE}, 0);
      chk("mr_data_zero", {PADDR, PWDATA}, 0);
      chk("mr_ready_zero", req_ready, 0);
      chk("mr_rsp_zero", rsp_valid, 0);
      @(posedge PCLK);
      #1 PRESETn = 1'b1;
      PREADY = 1'b1;
      tick();
      chk("mr_no_rsp1", rsp_valid, 0);
      tick();
      chk("mr_no_rsp2", rsp_valid, 0);
      req_valid = 2'b11; req_write = 2'b00;
      req_addr = {32'h220, 32'h110};
      #1 chk("mr_tie_after_reset", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("mr_tie_addr", PADDR, 32'h110);
      tick(); tick();
      chk("mr_tie_rsp", rsp_valid, 2'b01);
      tick();

      // Stalled slave: timeout build ends after 16 ACCESS cycles, otherwise waits on
      PREADY = 1'b0; PRDATA = 32'hFFFF_0000;
      req_valid = 2'b01; req_write = 2'b00; req_addr[AW-1:0] = 32'h40;
      #1 chk("to_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      tick();
      repeat (15) tick();
      chk("to_access16", {PSEL, PENABLE}, 2'b11);
      tick();
`ifdef APB_TIMEOUT_EN
      chk("to_rsp_valid", rsp_valid, 2'b01);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      chk("to_idle", {PSEL, PENABLE}, 2'b00);
      PREADY = 1'b1;
`else
      repeat (4) tick();
      chk("nto_still_access", {PSEL, PENABLE}, 2'b11);
      chk("nto_no_rsp", rsp_valid, 0);
      PREADY = 1'b1; PRDATA = 32'h0000_CAFE;
      tick();
      chk("nto_rsp_valid", rsp_valid, 2'b01);
      chk("nto_rsp_rdata", rsp_rdata, 32'h0000_CAFE);
      chk("nto_rsp_err", rsp_err, 0);
`endif
      tick();
      chk("end_idle", {PSEL, PENABLE, rsp_valid}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Two-port APB master that shares a single APB bus between two requesters. It arbitrates round-robin and sequences each APB transfer through its SETUP and ACCESS phases. It then returns the read data and slave error to the requester that issued the transfer. It sits between two on-chip clients (CPU-side bridge, DMA) and the APB slave interconnect.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait states (used only with APB_TIMEOUT_EN)

Ports (clock PCLK, single clock domain; reset PRESETn, asynchronous, active-low):
- PCLK  in  1  clock
- PRESETn  in  1  async active-low reset
- req_valid  in  2  request pending, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_valid  out  2  one-cycle completion pulse, bit i = requester i
- rsp_rdata  out  DATA_WIDTH  read data; shared, valid with rsp_valid
- rsp_err  out  1  PSLVERR (or timeout) of completed transfer
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_WIDTH

## Operation
- FSM states are IDLE, SETUP and ACCESS. Reset state is IDLE.
- IDLE:
  - req_ready is combinational and is the grant: one-hot over req_valid, asserted only in IDLE.
  - Arbitration: if exactly one requester is valid, grant it. If both are valid, grant the one not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - On a handshake (req_valid[i] & req_ready[i]), latch write/addr/wdata/owner and update last_grant. Next state is SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latches. Next state is ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. Address and control stay stable.
  - If PREADY=0, stay in ACCESS.
  - If PREADY=1, capture PRDATA (reads only; writes return 0) and PSLVERR. Go to IDLE.
- Completion: rsp_valid[owner] pulses high for exactly one cycle, the cycle after the PREADY sample, together with rsp_rdata/rsp_err. There is no backpressure; the requester must accept the response.
- APB outputs are registered. PWDATA is 0 on reads.
- Reset (including mid-transfer): all outputs go to 0 immediately, FSM returns to IDLE, last_grant=1. The in-flight transfer is dropped and no rsp_valid is issued.

## Timing
- Minimum transfer is 3 cycles: handshake (IDLE) -> SETUP -> ACCESS with PREADY=1. rsp_valid is asserted in the following IDLE cycle.
- A new grant may occur in the same IDLE cycle that carries rsp_valid. Back-to-back throughput is one transfer per 3 cycles.
- Each wait state (PREADY=0 in ACCESS) adds one cycle.
- A requester that drops req_valid before a grant is simply skipped. No request is ever accepted outside IDLE.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer ends as if PREADY=1, with rsp_err=1 and rsp_rdata=0. FSM returns to IDLE and PSEL/PENABLE drop.
- APB_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for PREADY and TIMEOUT_CYCLES is ignored.

## Test plan
- Reset values: assert PRESETn=0 -> PSEL=PENABLE=0, req_ready=0, rsp_valid=0, all data outputs 0.
- Single write, zero waits:
  - Stimulus: req 0 write, addr 0x10, data 0xA5A5_0001, PREADY=1.
  - Response: SETUP cycle then ACCESS cycle with PADDR=0x10, PWDATA=0xA5A5_0001, PWRITE=1; rsp_valid=2'b01, rsp_err=0 on cycle 4.
- Read with 3 wait states:
  - Stimulus: req 1 read, PRDATA=0xDEAD_BEEF, PSLVERR=1 on the ready cycle.
  - Response: ACCESS lasts 4 cycles; rsp_valid=2'b10, rsp_rdata=0xDEAD_BEEF, rsp_err=1.
- Contention: both requesters held valid for 4 transfers -> grants alternate 0,1,0,1; each requester's address appears on PADDR in that order.
- Reset mid-ACCESS with PREADY=0 -> outputs 0 at once; no rsp_valid; the next tie after reset is granted to requester 0.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 -> transfer ends after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0; FSM back in IDLE.
